sprite_shadow_commit: RTL and testbench

//  Upstream feeder for the sprite renderer register file. Host 16-bit writes land in a 10-word

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_shadow_commit.sv | 150 +++++++++++++++
 tb/tb_sprite_shadow_commit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared constants and types for the sprite shadow-commit block.
//   SPR_NUM_WORDS  shadow words (2 sprites x {coord, bmp[15:0], bmp[31:16], bmp[47:32], bmp[63:48]})
//   SPR_WORD_W     shadow/renderer word width
//   SPR_BASE_ADDR  register address of word 0; word i lives at SPR_BASE_ADDR + 2*i
//   spr_state_e    copy sequencer states
package sprite_pkg;

   localparam int         SPR_NUM_WORDS = 10;
   localparam int         SPR_WORD_W    = 16;
   localparam logic [5:0] SPR_BASE_ADDR = 6'h04;
   // Largest legal offset from SPR_BASE_ADDR (last word).
   localparam logic [5:0] SPR_LAST_OFF  = 6'(2 * (SPR_NUM_WORDS - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      DONE = 2'd2
   } spr_state_e;

   function automatic logic [5:0] spr_word_addr(input logic [3:0] idx);
      return SPR_BASE_ADDR + {1'b0, idx, 1'b0};
   endfunction

endpackage

// File: rtl/sprite_shadow_commit.sv
// sprite_shadow_commit
// Shadow bank feeding the sprite renderer's register file. Host writes land in a
// 10-word shadow bank at any time; a commit request is held pending and replayed
// into the renderer's live registers, one word per cycle, starting on the next
// VSYNC rising edge. Gives tear-free sprite updates without stopping the stream.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   host_wr_en/addr/data         host 16-bit write into the shadow bank
//   commit_req                   one-cycle pulse, request a commit at next frame
//   vsync                        renderer VSYNC level
//   eng_wr_en/addr/data          registered write port into the renderer
//   pending, busy, done          commit status (done is a one-cycle pulse)
//
// state | meaning
// IDLE  | waiting; a pending commit starts on a VSYNC rising edge
// COPY  | streaming shadow words to the renderer, one per cycle
// DONE  | one-cycle done pulse, then back to IDLE
module sprite_shadow_commit
   import sprite_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  host_wr_en,
   input  logic [5:0]            host_addr,
   input  logic [SPR_WORD_W-1:0] host_data,
   input  logic                  commit_req,
   input  logic                  vsync,
   output logic                  eng_wr_en,
   output logic [5:0]            eng_addr,
   output logic [SPR_WORD_W-1:0] eng_data,
   output logic                  pending,
   output logic                  busy,
   output logic                  done
);

   spr_state_e            state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   logic                  vs_prev_q, vs_prev_d;
   logic                  pending_q, pending_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  eng_wr_en_q, eng_wr_en_d;
   logic [5:0]            eng_addr_q, eng_addr_d;
   logic [SPR_WORD_W-1:0] eng_data_q, eng_data_d;
   logic [SPR_WORD_W-1:0] shadow_q [SPR_NUM_WORDS];
   logic [SPR_WORD_W-1:0] shadow_d [SPR_NUM_WORDS];

   logic [5:0] host_off;
   logic [3:0] host_idx;
   logic       host_hit;
   logic       vs_rise;

   // Unsigned wrap makes addresses below the base land far above SPR_LAST_OFF,
   // so one compare covers both ends of the window.
   always_comb begin
      host_off = host_addr - SPR_BASE_ADDR;
      host_idx = host_off[4:1];
      host_hit = host_wr_en && (host_off <= SPR_LAST_OFF) && !host_off[0];
      vs_rise  = vsync & ~vs_prev_q;
   end

   // idx_q is the index of the next word to load into the output registers, so
   // word 0 is loaded on the trigger edge and appears on the outputs one cycle
   // after the VSYNC rise. The emitted word is read from shadow_q, so a host
   // write in the same cycle cannot alter it.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      vs_prev_d   = vsync;
      pending_d   = pending_q | commit_req;
      busy_d      = busy_q;
      done_d      = 1'b0;
      eng_wr_en_d = 1'b0;
      eng_addr_d  = eng_addr_q;
      eng_data_d  = eng_data_q;
      shadow_d    = shadow_q;
      if (host_hit) begin
         shadow_d[host_idx] = host_data;
      end

      case (state_q)
         IDLE: begin
            // A commit_req arriving with the edge only sets pending.
            if (pending_q && vs_rise) begin
               state_d     = COPY;
               pending_d   = 1'b0;
               busy_d      = 1'b1;
               eng_wr_en_d = 1'b1;
               eng_addr_d  = spr_word_addr(4'd0);
               eng_data_d  = shadow_q[0];
               idx_d       = 4'd1;
            end
         end
         COPY: begin
            if (idx_q == 4'(SPR_NUM_WORDS)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               eng_wr_en_d = 1'b1;
               eng_addr_d  = spr_word_addr(idx_q);
               eng_data_d  = shadow_q[idx_q];
               idx_d       = idx_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         vs_prev_q   <= 1'b0;
         pending_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         eng_wr_en_q <= 1'b0;
         eng_addr_q  <= 6'd0;
         eng_data_q  <= '0;
         for (int i = 0; i < SPR_NUM_WORDS; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         vs_prev_q   <= vs_prev_d;
         pending_q   <= pending_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         eng_wr_en_q <= eng_wr_en_d;
         eng_addr_q  <= eng_addr_d;
         eng_data_q  <= eng_data_d;
         shadow_q    <= shadow_d;
      end
   end

   assign eng_wr_en = eng_wr_en_q;
   assign eng_addr  = eng_addr_q;
   assign eng_data  = eng_data_q;
   assign pending   = pending_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sprite_shadow_commit.sv
// Testbench for sprite_shadow_commit. Inputs are driven and outputs sampled on
// the falling edge. Expected renderer writes are queued before each frame and
// popped by the monitor whenever eng_wr_en is seen.
module tb_sprite_shadow_commit;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_wr_en;
   logic [5:0]  host_addr;
   logic [15:0] host_data;
   logic        commit_req;
   logic        vsync;
   logic        eng_wr_en;
   logic [5:0]  eng_addr;
   logic [15:0] eng_data;
   logic        pending;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [5:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        exp_e;
   logic [15:0] mdl [10];

   sprite_shadow_commit dut (
      .clk        (clk),
      .rst        (rst),
      .host_wr_en (host_wr_en),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .commit_req (commit_req),
      .vsync      (vsync),
      .eng_wr_en  (eng_wr_en),
      .eng_addr   (eng_addr),
      .eng_data   (eng_data),
      .pending    (pending),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Scoreboard: every renderer write must match the head of the queue.
   always @(negedge clk) begin
      if (eng_wr_en === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got addr=%h data=%h, required no write", eng_addr, eng_data);
         end else begin
            exp_e = exp_q.pop_front();
            if ({eng_addr, eng_data} !== {exp_e.addr, exp_e.data})
               $display("FAIL sb_word: got addr=%h data=%h, required addr=%h data=%h",
                        eng_addr, eng_data, exp_e.addr, exp_e.data);
            else
               n_pass++;
         end
      end
   end

   task automatic reset_dut();
      rst        = 1'b1;
      host_wr_en = 1'b0;
      host_addr  = 6'd0;
      host_data  = 16'd0;
      commit_req = 1'b0;
      vsync      = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) mdl[i] = 16'd0;
   endtask

   task automatic host_write(input logic [5:0] a, input logic [15:0] d);
      host_wr_en = 1'b1;
      host_addr  = a;
      host_data  = d;
      @(negedge clk);
      host_wr_en = 1'b0;
   endtask

   task automatic commit();
      commit_req = 1'b1;
      @(negedge clk);
      commit_req = 1'b0;
   endtask

   task automatic push_frame(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({6'(6'h04 + 2 * i), mdl[i]});
   endtask

   // Leaves vsync high on return: the current cycle is the rise cycle N.
   task automatic vsync_rise();
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      vsync = 1'b1;
   endtask

   task automatic test_reset();
      int seen;
      reset_dut();
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (eng_wr_en !== 1'b0) seen++;
      end
      n_checks++;
      if (seen !== 0) $display("FAIL reset_idle_wr: got %0d write cycles, required 0", seen);
      else n_pass++;
      n_checks++;
      if ({pending, busy, done} !== 3'b000)
         $display("FAIL reset_status: got pending/busy/done=%b, required 000", {pending, busy, done});
      else n_pass++;
      n_checks++;
      if ({eng_addr, eng_data} !== 22'd0)
         $display("FAIL reset_eng: got addr=%h data=%h, required 0/0", eng_addr, eng_data);
      else n_pass++;
   endtask

   task automatic test_basic_commit();
      int bad, done_n, done_c;
      host_write(6'h04, 16'h1234); mdl[0] = 16'h1234;
      host_write(6'h16, 16'hBEEF); mdl[9] = 16'hBEEF;
      commit();
      n_checks++;
      if ({pending, busy} !== 2'b10)
         $display("FAIL basic_pending: got pending/busy=%b, required 10", {pending, busy});
      else n_pass++;
      push_frame(10);
      vsync_rise();
      bad = 0; done_n = 0; done_c = -1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (eng_wr_en !== (c <= 10)) bad++;
         if (busy !== (c <= 10)) bad++;
         if (pending !== 1'b0) bad++;
         if (done === 1'b1) begin done_n++; done_c = c; end
      end
      n_checks++;
      if (bad !== 0) $display("FAIL basic_timing: got %0d bad wr/busy/pending samples, required 0", bad);
      else n_pass++;
      n_checks++;
      if (done_n !== 1 || done_c !== 11)
         $display("FAIL basic_done: got %0d pulses last at N+%0d, required 1 at N+11", done_n, done_c);
      else n_pass++;
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL basic_drain: got %0d words left, required 0", exp_q.size());
      else n_pass++;
      n_checks++;
      if ({eng_addr, eng_data} !== {6'h16, 16'hBEEF})
         $display("FAIL basic_hold: got addr=%h data=%h, required 16/beef", eng_addr, eng_data);
      else n_pass++;
   endtask

   task automatic test_commit_on_vsync();
      int wr_n, done_n;
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      commit_req = 1'b1;
      vsync      = 1'b1;
      @(negedge clk);
      commit_req = 1'b0;
      wr_n = 0;
      repeat (12) begin
         @(negedge clk);
         if (eng_wr_en === 1'b1) wr_n++;
      end
      n_checks++;
      if (wr_n !== 0) $display("FAIL same_cycle_nocopy: got %0d writes, required 0", wr_n);
      else n_pass++;
      n_checks++;
      if (pending !== 1'b1) $display("FAIL same_cycle_pending: got %b, required 1", pending);
      else n_pass++;
      push_frame(10);
      vsync_rise();
      wr_n = 0; done_n = 0;
      repeat (13) begin
         @(negedge clk);
         if (eng_wr_en === 1'b1) wr_n++;
         if (done === 1'b1) done_n++;
      end
      n_checks++;
      if (wr_n !== 10 || done_n !== 1)
         $display("FAIL next_frame_copy: got %0d writes %0d done, required 10 and 1", wr_n, done_n);
      else n_pass++;
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL next_frame_drain: got %0d left, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_read_before_write();
      reset_dut();
      host_write(6'h08, 16'h2222); mdl[2] = 16'h2222;
      host_write(6'h16, 16'h9999);
      mdl[9] = 16'h5555;
      commit();
      push_frame(10);
      vsync_rise();
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 3) begin
            n_checks++;
            if (eng_addr !== 6'h08) $display("FAIL rbw_align: got addr=%h at N+3, required 08", eng_addr);
            else n_pass++;
            host_wr_en = 1'b1; host_addr = 6'h08; host_data = 16'hAAAA;
         end else if (c == 4) begin
            host_addr = 6'h16; host_data = 16'h5555;
         end else if (c == 5) begin
            host_wr_en = 1'b0;
         end
      end
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL rbw_drain: got %0d left, required 0", exp_q.size());
      else n_pass++;
      mdl[2] = 16'hAAAA;
      commit();
      push_frame(10);
      vsync_rise();
      repeat (13) @(negedge clk);
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL rbw_second_drain: got %0d left, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_bad_addr();
      reset_dut();
      host_write(6'h02, 16'h1111);
      host_write(6'h05, 16'h2222);
      host_write(6'h18, 16'h3333);
      host_write(6'h3F, 16'h4444);
      host_write(6'h00, 16'h5555);
      commit();
      push_frame(10);
      vsync_rise();
      repeat (13) @(negedge clk);
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL badaddr_drain: got %0d left, required 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_copy();
      int done_n;
      reset_dut();
      host_write(6'h04, 16'h1111); mdl[0] = 16'h1111;
      host_write(6'h0E, 16'h5A5A); mdl[5] = 16'h5A5A;
      commit();
      push_frame(6);
      vsync_rise();
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 2) commit_req = 1'b1;
         if (c == 3) commit_req = 1'b0;
         if (c == 4) begin
            n_checks++;
            if (pending !== 1'b1) $display("FAIL copy_commit_pending: got %b, required 1", pending);
            else n_pass++;
         end
         if (c == 6) rst = 1'b1;
         if (c == 7) begin
            n_checks++;
            if ({eng_wr_en, busy, pending} !== 3'b000)
               $display("FAIL abort_status: got wr/busy/pending=%b, required 000", {eng_wr_en, busy, pending});
            else n_pass++;
            rst = 1'b0;
         end
      end
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL abort_drain: got %0d left, required 0", exp_q.size());
      else n_pass++;
      for (int i = 0; i < 10; i++) mdl[i] = 16'd0;
      commit();
      push_frame(10);
      vsync_rise();
      done_n = 0;
      repeat (13) begin
         @(negedge clk);
         if (done === 1'b1) done_n++;
      end
      n_checks++;
      if (exp_q.size() !== 0 || done_n !== 1)
         $display("FAIL after_abort: got %0d left %0d done, required 0 and 1", exp_q.size(), done_n);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_commit();
      test_commit_on_vsync();
      test_read_before_write();
      test_bad_addr();
      test_reset_mid_copy();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
